psg_sn_core: RTL and testbench



---
 rtl/psg_sn_core.sv | 241 ++++++++++++++++++++++++
 tb/tb_psg_sn_core.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psg_sn_core.sv
// SN76489-compatible sound generator: three square-wave tones, one LFSR noise
// channel, 2 dB-step attenuation, a latch/data byte-write port and a saturating mixer.
module psg_sn_core #(
    parameter int CLOCK_DIV           = 16,
    parameter int FREQ_BITS           = 10,
    parameter int CHANNEL_OUTPUT_BITS = 8,
    parameter int MASTER_OUTPUT_BITS  = 8,
    parameter int LFSR_BITS           = 15,
    parameter int WHITE_TAP           = 1,
    parameter int BUSY_CYCLES         = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    data_in,
    input  logic                          we,
    output logic                          ready,
    output logic [MASTER_OUTPUT_BITS-1:0] audio_out,
    output logic                          tick
);

    localparam int PRE_W  = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
    localparam int BUSY_W = $clog2(BUSY_CYCLES + 1);
    localparam int SUM_W  = CHANNEL_OUTPUT_BITS + 2;

    localparam logic [LFSR_BITS-1:0] LFSR_SEED = {1'b1, {(LFSR_BITS-1){1'b0}}};
    localparam logic [PRE_W-1:0]     PRE_LAST  = PRE_W'(CLOCK_DIV - 1);
    localparam logic [FREQ_BITS-1:0] ONE       = FREQ_BITS'(1);
    localparam logic [SUM_W-1:0]     SAT_LIMIT = SUM_W'((1 << CHANNEL_OUTPUT_BITS) - 1);

    function automatic logic [FREQ_BITS-1:0] reload_of(input logic [FREQ_BITS-1:0] period);
        return (period <= ONE) ? '0 : period - ONE;
    endfunction

    function automatic logic [FREQ_BITS-1:0] noise_period(input logic [1:0]           rate,
                                                          input logic [FREQ_BITS-1:0] tone2);
        logic [FREQ_BITS-1:0] p;
        case (rate)
            2'd0:    p = FREQ_BITS'(16);
            2'd1:    p = FREQ_BITS'(32);
            2'd2:    p = FREQ_BITS'(64);
            default: p = tone2;
        endcase
        return p;
    endfunction

    function automatic logic [7:0] attn_table(input logic [3:0] a);
        logic [7:0] v;
        case (a)
            4'd0:    v = 8'd255;
            4'd1:    v = 8'd203;
            4'd2:    v = 8'd161;
            4'd3:    v = 8'd128;
            4'd4:    v = 8'd102;
            4'd5:    v = 8'd81;
            4'd6:    v = 8'd64;
            4'd7:    v = 8'd51;
            4'd8:    v = 8'd40;
            4'd9:    v = 8'd32;
            4'd10:   v = 8'd25;
            4'd11:   v = 8'd20;
            4'd12:   v = 8'd16;
            4'd13:   v = 8'd13;
            4'd14:   v = 8'd10;
            default: v = 8'd0;
        endcase
        return v;
    endfunction

    logic [PRE_W-1:0]     pre_cnt;
    logic [BUSY_W-1:0]    busy_cnt;
    logic                 accept;

    logic [FREQ_BITS-1:0] freq     [3];
    logic [FREQ_BITS-1:0] freq_nxt [3];
    logic [3:0]           attn     [4];
    logic [3:0]           attn_nxt [4];
    logic [2:0]           noise_ctrl, noise_ctrl_nxt;
    logic [2:0]           latched_reg, latched_nxt;
    logic                 noise_write;

    logic [FREQ_BITS-1:0] tone_cnt [3];
    logic [2:0]           tone_out;

    logic [FREQ_BITS-1:0] noise_cnt;
    logic [FREQ_BITS-1:0] per_old, per_new;
    logic                 noise_run, noise_tog, noise_shift;
    logic [LFSR_BITS-1:0] lfsr;
    logic                 feedback;

    logic [3:0]                     ch_on;
    logic [CHANNEL_OUTPUT_BITS-1:0] vol [4];
    logic [SUM_W-1:0]               sum;

    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    assign ready  = (busy_cnt == '0);
    assign accept = we && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else if (accept) begin
            busy_cnt <= BUSY_W'(BUSY_CYCLES);
        end else if (!ready) begin
            busy_cnt <= busy_cnt - BUSY_W'(1);
        end
    end

    // Byte decode: latch bytes retarget and load the low nibble, data bytes use the stored target.
    always_comb begin
        freq_nxt       = freq;
        attn_nxt       = attn;
        noise_ctrl_nxt = noise_ctrl;
        latched_nxt    = latched_reg;
        noise_write    = 1'b0;
        if (accept) begin
            if (data_in[7]) begin
                latched_nxt = data_in[6:4];
                if (data_in[4]) begin
                    attn_nxt[data_in[6:5]] = data_in[3:0];
                end else if (data_in[6:5] != 2'd3) begin
                    freq_nxt[data_in[6:5]][3:0] = data_in[3:0];
                end else begin
                    noise_ctrl_nxt = data_in[2:0];
                    noise_write    = 1'b1;
                end
            end else begin
                if (latched_reg[0]) begin
                    attn_nxt[latched_reg[2:1]] = data_in[3:0];
                end else if (latched_reg[2:1] != 2'd3) begin
                    freq_nxt[latched_reg[2:1]][FREQ_BITS-1:4] = data_in[5:0];
                end else begin
                    noise_ctrl_nxt = data_in[2:0];
                    noise_write    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) freq[i] <= '0;
            for (int i = 0; i < 4; i++) attn[i] <= 4'hF;
            noise_ctrl  <= '0;
            latched_reg <= '0;
        end else begin
            for (int i = 0; i < 3; i++) freq[i] <= freq_nxt[i];
            for (int i = 0; i < 4; i++) attn[i] <= attn_nxt[i];
            noise_ctrl  <= noise_ctrl_nxt;
            latched_reg <= latched_nxt;
        end
    end

    // Run/stop and step decisions use the current period; reloads pick up a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) tone_cnt[i] <= '0;
            tone_out <= 3'b111;
        end else if (tick) begin
            for (int i = 0; i < 3; i++) begin
                if (freq[i] <= ONE) begin
                    tone_out[i] <= 1'b1;
                    tone_cnt[i] <= '0;
                end else if (tone_cnt[i] == '0) begin
                    tone_out[i] <= ~tone_out[i];
                    tone_cnt[i] <= reload_of(freq_nxt[i]);
                end else begin
                    tone_cnt[i] <= tone_cnt[i] - ONE;
                end
            end
        end
    end

    assign per_old     = noise_period(noise_ctrl[1:0], freq[2]);
    assign per_new     = noise_period(noise_ctrl_nxt[1:0], freq_nxt[2]);
    assign noise_run   = (per_old > ONE);
    assign noise_shift = tick && noise_run && (noise_cnt == '0) && !noise_tog;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            noise_cnt <= '0;
            noise_tog <= 1'b0;
        end else if (tick) begin
            if (!noise_run) begin
                noise_cnt <= '0;
            end else if (noise_cnt == '0) begin
                noise_tog <= ~noise_tog;
                noise_cnt <= reload_of(per_new);
            end else begin
                noise_cnt <= noise_cnt - ONE;
            end
        end
    end

    assign feedback = noise_ctrl[2] ? (lfsr[0] ^ lfsr[WHITE_TAP]) : lfsr[0];

    // A noise-control write reseeds, and an all-zero register could never recover by shifting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= LFSR_SEED;
        end else if (noise_write || (lfsr == '0)) begin
            lfsr <= LFSR_SEED;
        end else if (noise_shift) begin
            lfsr <= {feedback, lfsr[LFSR_BITS-1:1]};
        end
    end

    assign ch_on = {lfsr[0], tone_out};

    always_comb begin
        logic [7:0] scaled;
        scaled = '0;
        for (int i = 0; i < 4; i++) begin
            scaled = attn_table(attn[i]) >> (8 - CHANNEL_OUTPUT_BITS);
            vol[i] = ch_on[i] ? scaled[CHANNEL_OUTPUT_BITS-1:0] : '0;
        end
    end

    assign sum = SUM_W'(vol[0]) + SUM_W'(vol[1]) + SUM_W'(vol[2]) + SUM_W'(vol[3]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_out <= '0;
        end else if (sum > SAT_LIMIT) begin
            audio_out <= '1;
        end else begin
            audio_out <= sum[CHANNEL_OUTPUT_BITS-1 -: MASTER_OUTPUT_BITS];
        end
    end

endmodule

// File: tb/tb_psg_sn_core.sv
// Directed self-checking bench for psg_sn_core with default parameters
// (16 clk per tick, 8-bit channels and output, 15-bit LFSR, 4 busy cycles).
module tb_psg_sn_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       we;
    logic       ready;
    logic [7:0] audio_out;
    logic       tick;

    int errors = 0;
    int checks = 0;
    int tick_cnt;

    psg_sn_core dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .we        (we),
        .ready     (ready),
        .audio_out (audio_out),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    // Number of tick edges since reset was released.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tick_cnt <= 0;
        else if (tick) tick_cnt <= tick_cnt + 1;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation did not finish got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset();
        rst_n   = 1'b0;
        we      = 1'b0;
        data_in = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic apply_stimulus(input logic [7:0] b);
        int n;
        n = 0;
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL write_ready_timeout byte=%02h got ready=%b want 1", b, ready);
        end
        data_in = b;
        we      = 1'b1;
        @(posedge clk);
        #1;
        we      = 1'b0;
        data_in = 8'h00;
    endtask

    task automatic wait_ticks(input int target);
        int n;
        n = 0;
        while (tick_cnt < target && n < 40000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (tick_cnt < target) begin
            errors++;
            $display("[TB] FAIL tick_wait got=%0d want>=%0d", tick_cnt, target);
        end
    endtask

    task automatic wait_change(output int cycles);
        logic [7:0] prev;
        prev   = audio_out;
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (audio_out == prev && cycles < 10000);
    endtask

    task automatic test_reset();
        int n;
        int bad;
        rst_n   = 1'b0;
        we      = 1'b0;
        data_in = 8'h00;
        @(negedge clk);
        checks++;
        if (audio_out !== 8'd0) begin errors++; $display("[TB] FAIL reset_audio got=%0d want=0", audio_out); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b want=1", ready); end
        checks++;
        if (tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got=%b want=0", tick); end
        @(negedge clk);
        rst_n = 1'b1;

        n = 0;
        while (!tick && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 15) begin errors++; $display("[TB] FAIL first_tick_delay got=%0d want=15", n); end

        for (int p = 0; p < 4; p++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!tick && n < 100);
            checks++;
            if (n != 16) begin errors++; $display("[TB] FAIL tick_period[%0d] got=%0d want=16", p, n); end
        end

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (audio_out !== 8'd0 || ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL idle_quiet bad_samples got=%0d want=0", bad); end
    endtask

    task automatic test_tone();
        int c;
        do_reset();
        apply_stimulus(8'h8E);
        apply_stimulus(8'h0F);
        apply_stimulus(8'h90);
        repeat (2) @(negedge clk);
        checks++;
        if (audio_out !== 8'd255) begin errors++; $display("[TB] FAIL tone_full_scale got=%0d want=255", audio_out); end

        wait_change(c);
        checks++;
        if (audio_out !== 8'd0) begin errors++; $display("[TB] FAIL tone_first_low got=%0d want=0", audio_out); end
        wait_change(c);
        checks++;
        if (c != 4064) begin errors++; $display("[TB] FAIL tone_half_period_low got=%0d want=4064", c); end
        checks++;
        if (audio_out !== 8'd255) begin errors++; $display("[TB] FAIL tone_high_level got=%0d want=255", audio_out); end
        wait_change(c);
        checks++;
        if (c != 4064) begin errors++; $display("[TB] FAIL tone_half_period_high got=%0d want=4064", c); end
        checks++;
        if (audio_out !== 8'd0) begin errors++; $display("[TB] FAIL tone_low_level got=%0d want=0", audio_out); end
    endtask

    task automatic test_saturation();
        do_reset();
        // Tones sit high (freq 0); noise stays at seed with output 0 for now.
        apply_stimulus(8'h90); apply_stimulus(8'hB0); apply_stimulus(8'hD0); apply_stimulus(8'hF0);
        repeat (2) @(negedge clk);
        checks++;
        if (audio_out !== 8'd255) begin errors++; $display("[TB] FAIL sat_attn0 got=%0d want=255", audio_out); end

        apply_stimulus(8'h94); apply_stimulus(8'hB4); apply_stimulus(8'hD4); apply_stimulus(8'hF4);
        repeat (2) @(negedge clk);
        checks++;
        if (audio_out !== 8'd255) begin errors++; $display("[TB] FAIL sat_attn4 got=%0d want=255", audio_out); end

        apply_stimulus(8'h9C); apply_stimulus(8'hBC); apply_stimulus(8'hDC); apply_stimulus(8'hFC);
        repeat (2) @(negedge clk);
        checks++;
        if (audio_out !== 8'd48) begin errors++; $display("[TB] FAIL mix_attn12_three got=%0d want=48", audio_out); end

        // Periodic LFSR reaches 0x0001 at tick 417 and stays there until tick 449.
        wait_ticks(430);
        repeat (2) @(negedge clk);
        checks++;
        if (audio_out !== 8'd64) begin errors++; $display("[TB] FAIL mix_attn12_four got=%0d want=64", audio_out); end
    endtask

    task automatic test_noise();
        do_reset();
        apply_stimulus(8'hF0);
        apply_stimulus(8'hE4);
        wait_ticks(410);
        @(negedge clk);
        checks++;
        if (audio_out !== 8'd0) begin errors++; $display("[TB] FAIL noise_before_14th got=%0d want=0", audio_out); end
        wait_ticks(417);
        repeat (2) @(negedge clk);
        checks++;
        if (audio_out !== 8'd255) begin errors++; $display("[TB] FAIL noise_after_14th got=%0d want=255", audio_out); end
        wait_ticks(449);
        repeat (2) @(negedge clk);
        checks++;
        if (audio_out !== 8'd0) begin errors++; $display("[TB] FAIL noise_after_15th got=%0d want=0", audio_out); end
        wait_ticks(860);
        checks++;
        if (audio_out !== 8'd0) begin errors++; $display("[TB] FAIL noise_before_28th got=%0d want=0", audio_out); end
        // White feedback brings bit0 back at shift 28 (tick 865); periodic would not until tick 897.
        wait_ticks(870);
        checks++;
        if (audio_out !== 8'd255) begin errors++; $display("[TB] FAIL noise_white_28th got=%0d want=255", audio_out); end
        apply_stimulus(8'hE4);
        repeat (2) @(negedge clk);
        checks++;
        if (audio_out !== 8'd0) begin errors++; $display("[TB] FAIL noise_reseed got=%0d want=0", audio_out); end
    endtask

    task automatic test_dropped_write();
        int n;
        do_reset();
        data_in = 8'h90;
        we      = 1'b1;
        @(posedge clk);
        #1;
        data_in = 8'hC0;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL busy_after_write got=%b want=0", ready); end
        @(posedge clk);
        #1;
        we      = 1'b0;
        data_in = 8'h00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 50);
        checks++;
        if (n != 4) begin errors++; $display("[TB] FAIL busy_length got=%0d want=4", n); end
        checks++;
        if (audio_out !== 8'd255) begin errors++; $display("[TB] FAIL drop_audio got=%0d want=255", audio_out); end
        apply_stimulus(8'h05);
        repeat (2) @(negedge clk);
        checks++;
        if (audio_out !== 8'd81) begin errors++; $display("[TB] FAIL drop_latch_kept got=%0d want=81", audio_out); end
    endtask

    task automatic test_async_reset();
        int n;
        int bad;
        do_reset();
        apply_stimulus(8'h8E);
        apply_stimulus(8'h0F);
        apply_stimulus(8'h90);
        repeat (100) @(negedge clk);
        n = 0;
        while (audio_out !== 8'd255 && n < 10000) begin
            @(negedge clk);
            n++;
        end
        apply_stimulus(8'h90);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (audio_out !== 8'd0) begin errors++; $display("[TB] FAIL async_audio got=%0d want=0", audio_out); end
        checks++;
        if (ready !== 1'b1) begin errors++; $display("[TB] FAIL async_ready got=%b want=1", ready); end
        checks++;
        if (tick !== 1'b0) begin errors++; $display("[TB] FAIL async_tick got=%b want=0", tick); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (audio_out !== 8'd0) begin errors++; $display("[TB] FAIL post_reset_attn got=%0d want=0", audio_out); end
        apply_stimulus(8'h90);
        repeat (2) @(negedge clk);
        bad = 0;
        repeat (5000) begin
            @(negedge clk);
            if (audio_out !== 8'd255) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("[TB] FAIL post_reset_freq bad_samples got=%0d want=0", bad); end
    endtask

    initial begin
        rst_n   = 1'b0;
        we      = 1'b0;
        data_in = 8'h00;
        $display("[TB] starting psg_sn_core bench");
        test_reset();
        test_tone();
        test_saturation();
        test_noise();
        test_dropped_write();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
